// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and default framing constants for the UART path
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam int CLK_DIV_DEF = 868;
    localparam int DATA_BITS_DEF = 8;
    localparam int STOP_BITS_DEF = 1;
    localparam logic TXD_IDLE = 1'b1;
endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: byte handshake plus PISO control bundle
//   tx_valid/tx_ready : requester handshake
//   piso_load/piso_hold/piso_sdata : shift-register control and serial data
//   master = requester and PISO side, slave = controller side
interface uart_tx_ctrl_if;
    logic tx_valid;
    logic tx_ready;
    logic piso_load;
    logic piso_hold;
    logic piso_sdata;
    modport master (output tx_valid, output piso_sdata, input tx_ready, input piso_load, input piso_hold);
    modport slave (input tx_valid, input piso_sdata, output tx_ready, output piso_load, output piso_hold);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, tick marks the last cycle of each period
//   clk, rst_n (sync, active-low), clear : hold count at zero
//   tick : count == CLK_DIV-1, count : current phase within the bit
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    output logic                       tick,
    output logic [$clog2(CLK_DIV)-1:0] count
);
    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    assign tick = count == LAST;
    always_ff @(posedge clk) begin
        if (!rst_n || clear || tick) count <= '0;
        else count <= count + W'(1);
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer driving an external PISO
//   clk, rst_n (sync, active-low)
//   bus (slave) : tx_valid/tx_ready handshake, piso_load/piso_hold control, piso_sdata in
//   txd : serial line (idles high), busy : frame in progress
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int STOP_BITS = STOP_BITS_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_ctrl_if.slave bus,
    output logic          txd,
    output logic          busy
);
    localparam int BW = $clog2(CLK_DIV);
    localparam int MAXB = DATA_BITS > STOP_BITS ? DATA_BITS : STOP_BITS;
    localparam int CW = $clog2(MAXB + 1);
    localparam logic [BW-1:0] PRE_LAST = BW'(CLK_DIV - 2);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    uart_state_t state, state_n;
    logic [BW-1:0] baud_cnt;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic tick, accept, line, data_sel, hold;
    uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE),
        .tick  (tick),
        .count (baud_cnt)
    );
    assign bus.tx_ready = rst_n && state == IDLE;
    assign accept = bus.tx_valid && bus.tx_ready;
    assign bus.piso_load = accept;
    assign bus.piso_hold = hold;
    // PISO output is itself a flop; only the select is registered so each
    // shifted bit appears right at the bit boundary.
    assign txd = data_sel ? bus.piso_sdata : line;
    always_comb begin
        state_n = state;
        bit_cnt_n = bit_cnt;
        unique case (state)
            IDLE:    state_n = accept ? START : IDLE;
            START:   state_n = tick ? DATA : START;
            DATA:    state_n = tick && bit_cnt == DATA_LAST ? STOP : DATA;
            STOP:    state_n = tick && bit_cnt == STOP_LAST ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
        bit_cnt_n = state_n != state ? '0 : tick ? bit_cnt + CW'(1) : bit_cnt;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            bit_cnt <= '0;
            line <= TXD_IDLE;
            data_sel <= 1'b0;
            busy <= 1'b0;
            hold <= 1'b1;
        end else begin
            state <= state_n;
            bit_cnt <= bit_cnt_n;
            line <= state_n == START ? ~TXD_IDLE : TXD_IDLE;
            data_sel <= state_n == DATA;
            busy <= state_n != IDLE;
            // one-cycle-early decode so the registered release lands on the last cycle of a data bit
            hold <= !(state == DATA && baud_cnt == PRE_LAST);
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl at two parameter sets
module tb_uart_tx_ctrl;
    localparam int D0 = 4, S0 = 1, D1 = 3, S1 = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic txd0, busy0, txd1, busy1;
    logic [1:0] valid_a = 2'b00;
    logic [1:0] txd_a, busy_a, hold_a, load_a, ready_a;
    logic [7:0] pword [2];
    logic [7:0] sr0, sr1;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int checks = 0, errors = 0, cyc = 0;
    logic [1:0] in_f = 2'b00;
    int fc [2], pulses [2];
    bit ok [2];
    logic [7:0] dat [2];

    uart_tx_ctrl_if bus0 ();
    uart_tx_ctrl_if bus1 ();
    assign bus0.tx_valid = valid_a[0];
    assign bus1.tx_valid = valid_a[1];
    assign bus0.piso_sdata = sr0[0];
    assign bus1.piso_sdata = sr1[0];
    assign txd_a = {txd1, txd0};
    assign busy_a = {busy1, busy0};
    assign hold_a = {bus1.piso_hold, bus0.piso_hold};
    assign load_a = {bus1.piso_load, bus0.piso_load};
    assign ready_a = {bus1.tx_ready, bus0.tx_ready};

    uart_tx_ctrl #(.CLK_DIV(D0), .DATA_BITS(8), .STOP_BITS(S0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .txd(txd0), .busy(busy0));
    uart_tx_ctrl #(.CLK_DIV(D1), .DATA_BITS(8), .STOP_BITS(S1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .txd(txd1), .busy(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // LSB-first PISO models
    always @(posedge clk) begin
        if (bus0.piso_load) sr0 <= pword[0];
        else if (!bus0.piso_hold) sr0 <= sr0 >> 1;
        if (bus1.piso_load) sr1 <= pword[1];
        else if (!bus1.piso_hold) sr1 <= sr1 >> 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic send(input int k, input logic [7:0] b, input bit keep, output int t);
        int n;
        n = 0;
        @(negedge clk);
        pword[k] = b;
        valid_a[k] = 1'b1;
        if (k == 0) q0.push_back(b);
        else q1.push_back(b);
        #1;
        while (load_a[k] !== 1'b1 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        t = cyc;
        chk("accept", load_a[k], 1);
        @(negedge clk);
        pword[k] = ~b;
        if (!keep) valid_a[k] = 1'b0;
        #1;
        chk("load_one_cycle", load_a[k], 0);
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while ((k == 0 ? q0.size() : q1.size()) != 0 || in_f[k]) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: dut%0d still busy after %0d cycles, want idle", k, n);
                break;
            end
        end
    endtask

    // frame decoder / scoreboard
    always @(negedge clk) begin : mon
        int d, l, bi, sz;
        logic [7:0] e;
        #2;
        for (int k = 0; k < 2; k++) begin
            d = k == 0 ? D0 : D1;
            l = (9 + (k == 0 ? S0 : S1)) * d;
            if (!rst_n) begin
                if (in_f[k]) begin
                    if (k == 0 && q0.size() > 0) void'(q0.pop_front());
                    if (k == 1 && q1.size() > 0) void'(q1.pop_front());
                    in_f[k] = 1'b0;
                end
            end else begin
                if (load_a[k]) chk("load_hold_excl", hold_a[k], 1);
                if (valid_a[k] && !ready_a[k]) chk("load_gated", load_a[k], 0);
                if (in_f[k]) fc[k]++;
                else if (txd_a[k] === 1'b0) begin
                    in_f[k] = 1'b1;
                    fc[k] = 0;
                    ok[k] = 1'b1;
                    pulses[k] = 0;
                    dat[k] = '0;
                end
                if (in_f[k]) begin
                    if (fc[k] < l) begin
                        if (busy_a[k] !== 1'b1) ok[k] = 1'b0;
                        if (hold_a[k] === 1'b0) pulses[k]++;
                        if (fc[k] < d) begin
                            if (txd_a[k] !== 1'b0) ok[k] = 1'b0;
                        end else if (fc[k] < 9 * d) begin
                            bi = (fc[k] - d) / d;
                            if ((fc[k] - d) % d == 0) dat[k][bi] = txd_a[k];
                            else if (dat[k][bi] !== txd_a[k]) ok[k] = 1'b0;
                        end else if (txd_a[k] !== 1'b1) ok[k] = 1'b0;
                    end else begin
                        chk("frame_end_idle", {busy_a[k], txd_a[k]}, 2'b01);
                        chk("framing", ok[k], 1);
                        chk("shift_pulses", pulses[k], 8);
                        sz = k == 0 ? q0.size() : q1.size();
                        if (sz == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: dut%0d sent %0h, want no frame", k, dat[k]);
                        end else begin
                            e = k == 0 ? q0.pop_front() : q1.pop_front();
                            chk("frame_data", dat[k], e);
                        end
                        in_f[k] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        int t1, t2;
        pword[0] = '0;
        pword[1] = '0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_txd", txd_a, 2'b11);
            chk("rst_ready", ready_a, 2'b00);
            chk("rst_hold", hold_a, 2'b11);
            chk("rst_busy", busy_a, 2'b00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", ready_a, 2'b11);
        chk("hold_after_rst", hold_a, 2'b11);
        send(0, 8'hA5, 1'b0, t1);
        wait_done(0);
        send(0, 8'h00, 1'b1, t1);
        send(0, 8'hFF, 1'b0, t2);
        chk("b2b_spacing", t2 - t1, 41);
        send(0, 8'h3C, 1'b0, t1);
        repeat (12) @(negedge clk);
        send(0, 8'hC3, 1'b0, t2);
        chk("held_accept_spacing", t2 - t1, 41);
        wait_done(0);
        send(0, 8'h5A, 1'b0, t1);
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", ready_a[0], 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("abort_txd", txd0, 1);
            chk("abort_busy", busy0, 0);
            chk("abort_hold", hold_a[0], 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            #1;
            chk("post_abort_idle", {txd0, hold_a[0], busy0}, 3'b110);
        end
        send(0, 8'h96, 1'b0, t1);
        wait_done(0);
        send(1, 8'hA5, 1'b1, t1);
        send(1, 8'h0F, 1'b0, t2);
        chk("stop2_spacing", t2 - t1, 34);
        wait_done(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit sequencer for the UART TX path. It accepts a byte request over a valid/ready handshake and loads the existing 8-bit parallel-in/serial-out shift register. It then frames the serial stream as a start bit, DATA_BITS data bits and STOP_BITS stop bits, timed by an internal baud divider. It drives the PISO's load and shift-hold controls and owns the final txd line.

Parameters:
CLK_DIV, 868, clk cycles per bit period (100 MHz / 115200); legal range >= 2
DATA_BITS, 8, data bits per frame; must match PISO depth
STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
clk  input  1  single system clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
tx_valid  input  1  requester has a byte on the PISO parallel inputs
tx_ready  output  1  controller idle and able to accept a byte
piso_load  output  1  PISO load select; 1 = capture parallel word at next edge
piso_hold  output  1  drives PISO tx gate; 1 = freeze, 0 = shift one place at next edge
piso_sdata  input  1  PISO serial output (current data bit)
txd  output  1  UART serial line; idles high
busy  output  1  frame in progress (START, DATA or STOP)

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge), taking effect at that edge:
  - state=IDLE, baud_cnt=0, bit_cnt=0.
  - txd=1, busy=0, piso_hold=1, piso_load=0.
  - tx_ready=0 while rst_n=0; tx_ready=1 from the first cycle after rst_n=1.
- Reset mid-frame aborts the frame:
  - txd=1 from the next edge; no further piso_hold=0 pulses.
  - PISO contents are ignored.
- FSM states:
  - IDLE: txd=1, tx_ready=1, busy=0, piso_hold=1.
    - Accept when tx_valid & tx_ready (combinational piso_load=1 in that same cycle).
    - On accept: -> START, baud_cnt=0.
  - START: txd=0 for exactly CLK_DIV cycles.
    - When baud_cnt==CLK_DIV-1: -> DATA, bit_cnt=0, baud_cnt=0.
  - DATA: txd=piso_sdata (registered mux, no extra latency relative to bit boundary).
    - Each bit lasts CLK_DIV cycles.
    - In cycle baud_cnt==CLK_DIV-1: piso_hold=0 for exactly one cycle, which advances the PISO.
    - Then bit_cnt increments; after bit_cnt==DATA_BITS-1 completes: -> STOP.
    - Exactly DATA_BITS shift pulses per frame.
  - STOP: txd=1 for STOP_BITS*CLK_DIV cycles, then -> IDLE.
- Frame length: START entry to IDLE re-entry is exactly (1+DATA_BITS+STOP_BITS)*CLK_DIV cycles.
- Back-to-back traffic: with tx_valid held high, successive accepts are (1+DATA_BITS+STOP_BITS)*CLK_DIV+1 cycles apart.
- Handshake rules:
  - tx_valid while tx_ready=0 is ignored; piso_load stays 0.
  - The requester must hold data stable only in the accept cycle.
  - Accept has priority over nothing else: IDLE has a single exit.
- Counters:
  - baud_cnt is width clog2(CLK_DIV) and wraps to 0 on every bit boundary, never at CLK_DIV.
  - bit_cnt is width clog2(max(DATA_BITS,STOP_BITS)+1).
- Mutual exclusion: piso_load=1 never coincides with piso_hold=0.
- Output registering: txd, busy and piso_hold are registered. tx_ready is decoded from state. piso_load is the only combinational output.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP);
  - default CLK_DIV, DATA_BITS, STOP_BITS constants;
  - TXD_IDLE=1'b1.
- Sub-module uart_baud_cnt:
  - inputs: clk, rst_n, clear;
  - output: tick pulsed when count==CLK_DIV-1;
  - reused later by the RX side.

Test Plan:
- CLK_DIV=4, rst_n low 3 cycles then high -> txd=1, tx_ready=0 during reset, tx_ready=1 on first cycle after release, piso_hold=1.
- Send 8'hA5 (tx_valid one cycle) -> piso_load=1 that cycle only; txd=0 for 4 cycles; the 8 data bits match PISO output order at 4 cycles each; txd=1 for 4 cycles; 8 piso_hold=0 pulses; 40 cycles total.
- tx_valid held high, bytes 8'h00 then 8'hFF -> second accept exactly 41 cycles after first; no glitch on txd between frames.
- tx_valid asserted during DATA of a frame -> no piso_load, no accept until IDLE; frame bits unaffected.
- rst_n=0 at bit 3 of DATA -> txd=1 next edge, busy=0, no more shift pulses; a new byte after release transmits correctly.
- STOP_BITS=2, CLK_DIV=3 -> stop high for 6 cycles; frame is 33 cycles.
